id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage. It consumes the hazard unit's Stall_ID, Forward_R1/R1_2 and Forward_R2/R2_2 decisions.
- Selects forwarded operands, inserts bubbles on load-use stalls, and flushes on redirect.
- Drives WR_EX and LW_EX, which feed back to the hazard unit.
- Sits between the register file/decoder (ID) and the ALU (EX).

---
 rtl/id_ex_stage_reg.sv | 116 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with operand forwarding, bubble insertion on
// load-use stalls, flush on redirect and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int unsigned DW  = 32,
  parameter int unsigned CW  = 16,
  parameter int unsigned BCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  R1_data,
  input  logic [DW-1:0]  R2_data,
  input  logic [DW-1:0]  Result_EX,
  input  logic [DW-1:0]  Result_MEM,
  input  logic           Forward_R1,
  input  logic           Forward_R1_2,
  input  logic           Forward_R2,
  input  logic           Forward_R2_2,
  input  logic           Stall_ID,
  input  logic           Flush,
  input  logic [CW-1:0]  CTRL_ID,
  input  logic [4:0]     WR_ID,
  input  logic [DW-1:0]  PC_ID,
  input  logic [DW-1:0]  Imm_ID,
  output logic [DW-1:0]  A_EX,
  output logic [DW-1:0]  B_EX,
  output logic [DW-1:0]  Imm_EX,
  output logic [DW-1:0]  PC_EX,
  output logic [CW-1:0]  CTRL_EX,
  output logic [4:0]     WR_EX,
  output logic           LW_EX,
  output logic           Valid_EX,
  output logic [BCW-1:0] Bubble_Count
);

  localparam logic [BCW-1:0] BcMax = {BCW{1'b1}};

  logic [DW-1:0]  a_d, a_q;
  logic [DW-1:0]  b_d, b_q;
  logic [DW-1:0]  imm_d, imm_q;
  logic [DW-1:0]  pc_d, pc_q;
  logic [CW-1:0]  ctrl_d, ctrl_q;
  logic [4:0]     wr_d, wr_q;
  logic           valid_d, valid_q;
  logic [BCW-1:0] bc_d, bc_q;
  logic [DW-1:0]  a_sel, b_sel;
  logic           bubble;

  // Forwarding muxes: the EX result is younger than MEM, so it wins.
  always_comb begin
    a_sel = Forward_R1 ? Result_EX : (Forward_R1_2 ? Result_MEM : R1_data);
    b_sel = Forward_R2 ? Result_EX : (Forward_R2_2 ? Result_MEM : R2_data);
  end

  // Next-state: flush and stall both load an all-zero bubble; otherwise capture ID.
  always_comb begin
    bubble  = Flush | Stall_ID;
    a_d     = '0;
    b_d     = '0;
    imm_d   = '0;
    pc_d    = '0;
    ctrl_d  = '0;
    wr_d    = '0;
    valid_d = 1'b0;
    bc_d    = bc_q;
    if (bubble) begin
      if (bc_q != BcMax) begin
        bc_d = bc_q + 1'b1;
      end
    end else begin
      a_d     = a_sel;
      b_d     = b_sel;
      imm_d   = Imm_ID;
      pc_d    = PC_ID;
      ctrl_d  = CTRL_ID;
      wr_d    = WR_ID;
      valid_d = 1'b1;
    end
  end

  // Stage register; reset overrides everything, including a concurrent stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
      bc_q    <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      bc_q    <= bc_d;
    end
  end

  // Outputs come straight from flops; LW_EX is just the load bit of the control bundle.
  always_comb begin
    A_EX         = a_q;
    B_EX         = b_q;
    Imm_EX       = imm_q;
    PC_EX        = pc_q;
    CTRL_EX      = ctrl_q;
    WR_EX        = wr_q;
    LW_EX        = ctrl_q[0];
    Valid_EX     = valid_q;
    Bubble_Count = bc_q;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with a scoreboard queue of expected EX state.
module tb_id_ex_stage_reg;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned BCW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  R1_data, R2_data, Result_EX, Result_MEM;
  logic           Forward_R1, Forward_R1_2, Forward_R2, Forward_R2_2;
  logic           Stall_ID, Flush;
  logic [CW-1:0]  CTRL_ID;
  logic [4:0]     WR_ID;
  logic [DW-1:0]  PC_ID, Imm_ID;
  logic [DW-1:0]  A_EX, B_EX, Imm_EX, PC_EX;
  logic [CW-1:0]  CTRL_EX;
  logic [4:0]     WR_EX;
  logic           LW_EX, Valid_EX;
  logic [BCW-1:0] Bubble_Count;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  pc;
    logic [CW-1:0]  ctrl;
    logic [4:0]     wr;
    logic           lw;
    logic           valid;
    logic [BCW-1:0] bc;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad   = 0;
  logic [BCW-1:0] m_bc  = '0;

  id_ex_stage_reg #(.DW(DW), .CW(CW), .BCW(BCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .R1_data      (R1_data),
    .R2_data      (R2_data),
    .Result_EX    (Result_EX),
    .Result_MEM   (Result_MEM),
    .Forward_R1   (Forward_R1),
    .Forward_R1_2 (Forward_R1_2),
    .Forward_R2   (Forward_R2),
    .Forward_R2_2 (Forward_R2_2),
    .Stall_ID     (Stall_ID),
    .Flush        (Flush),
    .CTRL_ID      (CTRL_ID),
    .WR_ID        (WR_ID),
    .PC_ID        (PC_ID),
    .Imm_ID       (Imm_ID),
    .A_EX         (A_EX),
    .B_EX         (B_EX),
    .Imm_EX       (Imm_EX),
    .PC_EX        (PC_EX),
    .CTRL_EX      (CTRL_EX),
    .WR_EX        (WR_EX),
    .LW_EX        (LW_EX),
    .Valid_EX     (Valid_EX),
    .Bubble_Count (Bubble_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; R1_data = '0; R2_data = '0; Result_EX = '0; Result_MEM = '0;
    Forward_R1 = 0; Forward_R1_2 = 0; Forward_R2 = 0; Forward_R2_2 = 0;
    Stall_ID = 0; Flush = 0; CTRL_ID = '0; WR_ID = '0; PC_ID = '0; Imm_ID = '0;
  endtask

  // Reference model: predict EX state from the current inputs, push it, clock, then compare.
  task automatic step();
    exp_t e;
    e = '0;
    if (rst) begin
      m_bc = '0;
    end else if (Flush || Stall_ID) begin
      if (m_bc != {BCW{1'b1}}) m_bc = m_bc + 1'b1;
    end else begin
      e.a     = Forward_R1 ? Result_EX : (Forward_R1_2 ? Result_MEM : R1_data);
      e.b     = Forward_R2 ? Result_EX : (Forward_R2_2 ? Result_MEM : R2_data);
      e.imm   = Imm_ID;
      e.pc    = PC_ID;
      e.ctrl  = CTRL_ID;
      e.wr    = WR_ID;
      e.lw    = CTRL_ID[0];
      e.valid = 1'b1;
    end
    e.bc = m_bc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("A_EX", A_EX, e.a);
    chk("B_EX", B_EX, e.b);
    chk("Imm_EX", Imm_EX, e.imm);
    chk("PC_EX", PC_EX, e.pc);
    chk("CTRL_EX", {16'h0, CTRL_EX}, {16'h0, e.ctrl});
    chk("WR_EX", {27'h0, WR_EX}, {27'h0, e.wr});
    chk("LW_EX", {31'h0, LW_EX}, {31'h0, e.lw});
    chk("Valid_EX", {31'h0, Valid_EX}, {31'h0, e.valid});
    chk("Bubble_Count", {28'h0, Bubble_Count}, {28'h0, e.bc});
  endtask

  initial begin
    idle_inputs();
    // Reset
    rst = 1; R1_data = 32'hDEAD; WR_ID = 5'd3; CTRL_ID = 16'hFFFF;
    step();
    chk("reset_valid", {31'h0, Valid_EX}, 32'h0);

    // Pass-through
    idle_inputs();
    R1_data = 32'h11; R2_data = 32'h22; WR_ID = 5'd5; CTRL_ID = 16'h0002;
    PC_ID = 32'h100; Imm_ID = 32'hFFFF_FFF0;
    step();
    chk("pass_A", A_EX, 32'h11);
    chk("pass_B", B_EX, 32'h22);
    chk("pass_WR", {27'h0, WR_EX}, 32'd5);
    chk("pass_LW", {31'h0, LW_EX}, 32'h0);

    // Forward priority: EX beats MEM on A, MEM used on B
    R1_data = 32'h1; Result_EX = 32'hAAAA; Result_MEM = 32'hBBBB;
    Forward_R1 = 1; Forward_R1_2 = 1; Forward_R2_2 = 1;
    step();
    chk("fwd_A", A_EX, 32'hAAAA);
    chk("fwd_B", B_EX, 32'hBBBB);
    Forward_R1 = 0; Forward_R1_2 = 0; Forward_R2_2 = 0; Forward_R2 = 1;
    step();

    // Load-use sequence
    idle_inputs();
    WR_ID = 5'd8; CTRL_ID = 16'h0003; PC_ID = 32'h200;
    step();
    chk("lu_lw", {31'h0, LW_EX}, 32'h1);
    chk("lu_wr", {27'h0, WR_EX}, 32'd8);
    WR_ID = 5'd9; CTRL_ID = 16'h0002; R1_data = 32'h5;
    Stall_ID = 1;
    step();
    chk("lu_bubble_bc", {28'h0, Bubble_Count}, 32'd1);
    chk("lu_bubble_wr", {27'h0, WR_EX}, 32'd0);
    Stall_ID = 0; Forward_R1_2 = 1; Result_MEM = 32'h1234;
    step();
    chk("lu_fwd_A", A_EX, 32'h1234);
    chk("lu_valid", {31'h0, Valid_EX}, 32'h1);

    // Flush beats stall
    Flush = 1; Stall_ID = 1;
    step();
    chk("flush_bc", {28'h0, Bubble_Count}, 32'd2);
    chk("flush_ctrl", {16'h0, CTRL_EX}, 32'h0);

    // Randomised traffic with occasional bubbles
    for (int i = 0; i < 16; i++) begin
      R1_data = $urandom; R2_data = $urandom; Result_EX = $urandom; Result_MEM = $urandom;
      {Forward_R1, Forward_R1_2, Forward_R2, Forward_R2_2} = 4'($urandom);
      Stall_ID = ($urandom_range(0, 3) == 0); Flush = ($urandom_range(0, 5) == 0);
      CTRL_ID = 16'($urandom); WR_ID = 5'($urandom); PC_ID = $urandom; Imm_ID = $urandom;
      step();
    end

    // Saturation
    idle_inputs();
    Stall_ID = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_bc", {28'h0, Bubble_Count}, 32'd15);

    // Reset during stall wins
    rst = 1;
    step();
    chk("rst_stall_bc", {28'h0, Bubble_Count}, 32'd0);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
